// File: rtl/trackball_if.sv
// -----------------------------------------------------------------------------
// trackball_if
// Bundles the mouse-side inputs and trakball-side outputs of the trackball
// sequencer so the top level and the testbench connect through one port.
//
// Signals:
//   mouse_pkt  ps2_mouse packet: [24] toggle, [23:16] dy, [15:8] dx,
//              [5] y sign, [4] x sign
//   sense      step period multiplier, period = BASE_DIV*(sense+1) cycles
//   invert     negate both axes
//   enable     0 pauses draining; packets are still accumulated
//   trak_o     {x_dir, x_clk, y_dir, y_clk}
//   x_pending  x accumulator non-zero
//   y_pending  y accumulator non-zero
//
// Transfer semantics: there is no valid/ready pair. A packet is offered by
// flipping mouse_pkt[24] and is consumed unconditionally on the next clk_sys
// edge; the sequencer never back-pressures. The payload must be stable on the
// edge where the toggle change is first seen.
// -----------------------------------------------------------------------------
interface trackball_if;
    logic [24:0] mouse_pkt;
    logic [2:0]  sense;
    logic        invert;
    logic        enable;
    logic [3:0]  trak_o;
    logic        x_pending;
    logic        y_pending;

    modport master (
        output mouse_pkt, sense, invert, enable,
        input  trak_o, x_pending, y_pending
    );

    modport slave (
        input  mouse_pkt, sense, invert, enable,
        output trak_o, x_pending, y_pending
    );
endinterface

// File: rtl/trackball_sequencer.sv
// -----------------------------------------------------------------------------
// trackball_sequencer
// Turns PS/2 mouse packets into the direction/clock pairs sampled by the
// centipede core on trakball_i. Signed motion is accumulated per axis and
// drained one step per tick; the tick period is BASE_DIV*(sense+1) cycles.
//
// Ports:
//   clk_sys  system clock
//   reset    synchronous, active-high reset
//   bus      trackball_if.slave: mouse_pkt/sense/invert/enable in,
//            trak_o/x_pending/y_pending out
//
// Parameters:
//   ACC_W     accumulator width per axis (signed, >= 10)
//   BASE_DIV  clk_sys cycles per prescaler period (>= 1)
//   DIV_W     prescaler width, must hold BASE_DIV-1
// -----------------------------------------------------------------------------
module trackball_sequencer #(
    parameter int ACC_W    = 12,
    parameter int BASE_DIV = 256,
    parameter int DIV_W    = 9
) (
    input  logic          clk_sys,
    input  logic          reset,
    trackball_if.slave    bus
);

    // Sums are formed two bits wider than the accumulator so that
    // acc - step + delta can never wrap before it is clamped.
    localparam int SUM_W = ACC_W + 2;
    localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'((1 << (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN  = -SAT_MAX;
    localparam logic signed [SUM_W-1:0] ONE      = SUM_W'(1);
    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(BASE_DIV - 1);

    logic [DIV_W-1:0]        pre_cnt;
    logic [2:0]              sub_cnt;
    logic                    last_tog;
    logic signed [ACC_W-1:0] acc_x, acc_y;
    logic signed [ACC_W-1:0] next_x, next_y;
    logic                    x_dir, x_clk, y_dir, y_clk;
    logic                    x_pend_q, y_pend_q;

    logic                    pkt;
    logic                    wrap;
    logic                    tick;
    logic                    x_step, y_step;
    logic signed [SUM_W-1:0] dx, dy;

    // Payload bits the core does not use (buttons, overflow flags).
    logic unused_pkt_bits;
    assign unused_pkt_bits = ^{bus.mouse_pkt[7:6], bus.mouse_pkt[3:0]};

    // Sign-extended 9-bit delta, optionally negated, zero without a packet.
    function automatic logic signed [SUM_W-1:0] delta(
        input logic       sgn,
        input logic [7:0] mag,
        input logic       inv,
        input logic       valid
    );
        logic signed [SUM_W-1:0] d;
        d = {{(SUM_W - 8){sgn}}, mag};
        if (inv) d = -d;
        if (!valid) d = '0;
        return d;
    endfunction

    // acc - sign(acc)*step + d, clamped symmetrically. The step sign is taken
    // from the pre-update accumulator; step is only requested when acc != 0.
    function automatic logic signed [ACC_W-1:0] acc_update(
        input logic signed [ACC_W-1:0] acc,
        input logic                    step,
        input logic signed [SUM_W-1:0] d
    );
        logic signed [SUM_W-1:0] sum;
        sum = {{2{acc[ACC_W-1]}}, acc} + d;
        if (step) begin
            if (acc[ACC_W-1]) sum = sum + ONE;
            else              sum = sum - ONE;
        end
        if (sum > SAT_MAX)      sum = SAT_MAX;
        else if (sum < SAT_MIN) sum = SAT_MIN;
        return sum[ACC_W-1:0];
    endfunction

    assign pkt  = bus.mouse_pkt[24] ^ last_tog;
    assign wrap = bus.enable && (pre_cnt == DIV_LAST);
    // >= rather than == so that lowering sense mid-count ticks at the next
    // wrap instead of waiting for sub_cnt to roll over.
    assign tick = wrap && (sub_cnt >= bus.sense);

    assign dx = delta(bus.mouse_pkt[4], bus.mouse_pkt[15:8],  bus.invert, pkt);
    assign dy = delta(bus.mouse_pkt[5], bus.mouse_pkt[23:16], bus.invert, pkt);

    assign x_step = tick && (acc_x != '0);
    assign y_step = tick && (acc_y != '0);

    assign next_x = acc_update(acc_x, x_step, dx);
    assign next_y = acc_update(acc_y, y_step, dy);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pre_cnt  <= '0;
            sub_cnt  <= '0;
            // Capture the current toggle so a stale level is not a packet.
            last_tog <= bus.mouse_pkt[24];
            acc_x    <= '0;
            acc_y    <= '0;
            x_pend_q <= 1'b0;
            y_pend_q <= 1'b0;
            x_dir    <= 1'b0;
            x_clk    <= 1'b0;
            y_dir    <= 1'b0;
            y_clk    <= 1'b0;
        end else begin
            last_tog <= bus.mouse_pkt[24];

            if (bus.enable) begin
                if (wrap) begin
                    pre_cnt <= '0;
                    sub_cnt <= tick ? 3'd0 : sub_cnt + 3'd1;
                end else begin
                    pre_cnt <= pre_cnt + DIV_W'(1);
                end
            end

            acc_x    <= next_x;
            acc_y    <= next_y;
            x_pend_q <= (next_x != '0);
            y_pend_q <= (next_y != '0);

            // Stepping requires acc != 0, so a clear sign bit means acc > 0.
            if (x_step) begin
                x_dir <= ~acc_x[ACC_W-1];
                x_clk <= ~x_clk;
            end
            if (y_step) begin
                y_dir <= ~acc_y[ACC_W-1];
                y_clk <= ~y_clk;
            end
        end
    end

    assign bus.trak_o    = {x_dir, x_clk, y_dir, y_clk};
    assign bus.x_pending = x_pend_q;
    assign bus.y_pending = y_pend_q;

endmodule

// File: doc/trackball_sequencer.md
Name: trackball_sequencer

Overview:
- Converts PS/2 mouse packets from hps_io into the direction/clock trackball pairs the centipede core samples on trakball_i.
- Accumulates signed per-axis motion, then drains it one step at a time on a programmable tick derived from the OSD mouse-sensitivity setting.
- Sits between ps2_mouse and the core's trakball input, in the clk_sys domain. Replaces the ad-hoc trakdata logic in the top level.

Parameters:
- ACC_W, 12: accumulator width per axis (signed).
- BASE_DIV, 256: clk_sys cycles per prescaler period (>=1).
- DIV_W, 9: prescaler counter width; must hold BASE_DIV-1.

Ports:
- clk_sys  in  1  system clock (12 MHz).
- reset  in  1  synchronous, active-high reset.
- mouse_pkt  in  25  ps2_mouse format: [24] toggle, [23:16] dy, [15:8] dx, [5] y sign, [4] x sign.
- sense  in  3  step period multiplier; period = BASE_DIV*(sense+1) cycles.
- invert  in  1  negate both axes (core flip_o).
- enable  in  1  0 = paused: no steps drained, packets still accumulated.
- trak_o  out  4  {x_dir, x_clk, y_dir, y_clk}.
- x_pending  out  1  x accumulator non-zero.
- y_pending  out  1  y accumulator non-zero.

Behaviour:
- Clock and reset: one clock, clk_sys. reset is synchronous, active-high.
- Reset values:
  - accumulators 0, prescaler 0, sub-counter 0.
  - trak_o = 4'b0000, x_pending = y_pending = 0.
  - last_tog <= mouse_pkt[24], so a packet is not detected on the first cycle after reset.
- Packet detect: pkt = (mouse_pkt[24] != last_tog). last_tog updates every cycle. Only a change of the toggle bit counts as a packet; a stable toggle never re-triggers.
- Delta:
  - d = 9-bit signed {sign, byte}, sign-extended to ACC_W; range -256..+255.
  - If invert = 1, d = -d.
  - d is forced to 0 when pkt = 0.
- Tick generation:
  - When enable = 1, the prescaler counts 0..BASE_DIV-1 and wraps.
  - At prescaler wrap: if sub >= sense, tick = 1 for one cycle and sub <= 0; else sub <= sub+1.
  - The >= comparison means lowering sense mid-count yields a tick at the next wrap and never a stall.
  - When enable = 0, prescaler and sub hold and tick = 0.
- Step per axis, on tick with acc != 0:
  - s = sign(acc): +1 or -1.
  - dir <= (acc > 0).
  - clk <= ~clk.
  - With tick = 0 or acc = 0, s = 0 and dir/clk hold.
- Update per axis: acc <= sat(acc - s + d).
  - The step sign is taken from the pre-update acc.
  - A simultaneous packet and step are both applied in the same cycle.
  - sat clamps to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)], i.e. ±2047 at the default width.
  - The sum is computed at ACC_W+2 bits before clamping, so no wrap is possible.
- Latency and rate:
  - Packet to accumulator: 1 cycle.
  - First step occurs at the next tick after the accumulator is non-zero.
  - At most one clk toggle per axis per tick.
  - x and y step on the same tick, independently.
- Pending: x_pending = (acc_x != 0), registered alongside acc (same cycle acc changes).
- Reset mid-operation: accumulated motion is discarded and outputs return to reset values the cycle after reset is sampled. No residual toggles follow.
- Pause: trak_o holds its last value while enable = 0. Packets keep accumulating, with saturation.

Test Plan:
- Basic drain. BASE_DIV=4, sense=0; after reset, toggle the packet with dx=+5 (sign 0, byte 0x05), dy=0 -> x_clk toggles exactly 5 times, 4 cycles apart, x_dir=1; y_clk and y_dir stay 0; x_pending falls on the 5th step.
- Negative motion. dx byte 0xFD with sign 1 (-3) -> x_dir=0 and 3 toggles. Same packet with invert=1 -> x_dir=1 and 3 toggles.
- Sensitivity. BASE_DIV=4, sense=3, dy=+2 -> y_clk toggles 16 cycles apart. Change sense to 0 mid-count -> next toggle at the next prescaler wrap (≤4 cycles).
- Saturation and pause. enable=0; send 20 packets of dx=+255 -> x_pending=1 and trak_o unchanged. enable=1 -> exactly 2047 x_clk toggles, then x_pending=0.
- Simultaneous events. acc_x=+1; a packet with dx=-1 arrives on a tick cycle -> one toggle with x_dir=1, acc_x ends at -1 (1 - 1 + (-1)), then one more toggle with x_dir=0, then acc_x = 0.
- Reset mid-drain. With acc_x=10 draining, assert reset for 1 cycle -> trak_o=0 and x_pending=0 next cycle, no further toggles. A held toggle bit after reset produces no packet.
